// File: rtl/mac_job_sequencer.sv
// mac_job_sequencer
// Job-level controller for the MAC datapath engine. Job descriptors are
// queued in a small FIFO. Each job is then run on the engine in the order
// clear, configure/start, count output handshakes, wait for streamer done,
// and signal done.
module mac_job_sequencer #(
    parameter int CNT_W          = 10,
    parameter int NOUT_W         = 16,
    parameter int ID_W           = 4,
    parameter int JOB_FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              soft_clear_i,
    // job descriptor side
    input  logic              job_valid_i,
    output logic              job_ready_o,
    input  logic [CNT_W-1:0]  job_len_i,
    input  logic [5:0]        job_shift_i,
    input  logic              job_simple_mul_i,
    input  logic [NOUT_W-1:0] job_nb_out_i,
    input  logic [ID_W-1:0]   job_id_i,
    // engine control
    output logic              eng_clear_o,
    output logic              eng_enable_o,
    output logic              eng_start_o,
    output logic [CNT_W-1:0]  eng_len_o,
    output logic [5:0]        eng_shift_o,
    output logic              eng_simple_mul_o,
    // monitored engine output stream
    input  logic              d_valid_i,
    input  logic              d_ready_i,
    // streamer control
    output logic              strm_start_o,
    input  logic              strm_done_i,
    // status
    output logic              busy_o,
    output logic              done_o,
    output logic [ID_W-1:0]   done_id_o,
    output logic [NOUT_W-1:0] out_cnt_o
);

    localparam int PTR_W = (JOB_FIFO_DEPTH > 1) ? $clog2(JOB_FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(JOB_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [CNT_W-1:0]  len;
        logic [5:0]        shift;
        logic              simple_mul;
        logic [NOUT_W-1:0] nb_out;
        logic [ID_W-1:0]   id;
    } job_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_START     = 3'd2,
        S_RUN       = 3'd3,
        S_WAIT_STRM = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    // Descriptor FIFO storage and bookkeeping
    job_t             fifo_mem [JOB_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    job_t             push_job;
    job_t             head_job;

    // Active job and sequencing state
    job_t              act_q;
    state_t            state_q;
    state_t            state_d;
    logic [NOUT_W-1:0] out_cnt_q;
    logic              strm_done_q;
    logic              handshake;
    logic              last_handshake;

    assign fifo_full  = (occ_q == OCC_W'(JOB_FIFO_DEPTH));
    assign fifo_empty = (occ_q == '0);

    // Ready depends only on FIFO space, never on job_valid_i, so there is
    // no combinational valid->ready path back to the register file.
    assign job_ready_o = ~fifo_full;

    // A push coinciding with a soft clear is discarded together with the
    // rest of the queue.
    assign push = job_valid_i & ~fifo_full & ~soft_clear_i;

    // The head is taken only while idle; the state moves to CLEAR on the
    // same edge, so one job is popped per visit to IDLE.
    assign pop = (state_q == S_IDLE) & ~fifo_empty & ~soft_clear_i;

    assign push_job.len        = job_len_i;
    assign push_job.shift      = job_shift_i;
    assign push_job.simple_mul = job_simple_mul_i;
    assign push_job.nb_out     = job_nb_out_i;
    assign push_job.id         = job_id_i;

    assign head_job = fifo_mem[rd_ptr_q];

    assign handshake = d_valid_i & d_ready_i;

    // nb_out is at least 1 whenever RUN is reached, so the subtraction
    // never wraps while it matters.
    assign last_handshake = handshake & (out_cnt_q == act_q.nb_out - NOUT_W'(1));

    // Descriptor payload storage; data only, so it carries no reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_job;
        end
    end

    // FIFO pointers and occupancy; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else if (soft_clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Active job registers, loaded from the FIFO head when a job is launched
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_q <= '0;
        end else if (pop) begin
            act_q <= head_job;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and engine/streamer control decode
    always_comb begin
        state_d      = state_q;
        eng_clear_o  = 1'b0;
        eng_enable_o = 1'b0;
        eng_start_o  = 1'b0;
        strm_start_o = 1'b0;
        done_o       = 1'b0;
        done_id_o    = '0;

        if (soft_clear_i) begin
            // Abort: clear the engine this cycle, everything else stays low
            state_d     = S_IDLE;
            eng_clear_o = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state_d = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    eng_clear_o = 1'b1;
                    // A job with no outputs completes without touching the
                    // engine or the streamer.
                    if (act_q.nb_out == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    eng_enable_o = 1'b1;
                    eng_start_o  = 1'b1;
                    strm_start_o = 1'b1;
                    state_d      = S_RUN;
                end
                S_RUN: begin
                    eng_enable_o = 1'b1;
                    if (last_handshake) begin
                        state_d = S_WAIT_STRM;
                    end
                end
                S_WAIT_STRM: begin
                    eng_enable_o = 1'b1;
                    if (strm_done_i || strm_done_q) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    // DONE always returns to IDLE, so done_o is a single
                    // cycle pulse and jobs are separated by one idle bubble.
                    done_o    = 1'b1;
                    done_id_o = act_q.id;
                    state_d   = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output handshake counter and sticky streamer-done flag for the active job
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_cnt_q   <= '0;
            strm_done_q <= 1'b0;
        end else if (soft_clear_i) begin
            out_cnt_q   <= '0;
            strm_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    out_cnt_q   <= '0;
                    strm_done_q <= 1'b0;
                end
                S_START: begin
                    // The streamer may finish before the engine does, so
                    // remember a done pulse seen in START, RUN or WAIT_STRM.
                    strm_done_q <= strm_done_q | strm_done_i;
                end
                S_RUN: begin
                    strm_done_q <= strm_done_q | strm_done_i;
                    if (handshake && (out_cnt_q != act_q.nb_out)) begin
                        out_cnt_q <= out_cnt_q + NOUT_W'(1);
                    end
                end
                S_WAIT_STRM: begin
                    strm_done_q <= strm_done_q | strm_done_i;
                end
                default: begin
                    out_cnt_q   <= out_cnt_q;
                    strm_done_q <= strm_done_q;
                end
            endcase
        end
    end

    assign busy_o           = (state_q != S_IDLE) | ~fifo_empty;
    assign out_cnt_o        = out_cnt_q;
    assign eng_len_o        = act_q.len;
    assign eng_shift_o      = act_q.shift;
    assign eng_simple_mul_o = act_q.simple_mul;

endmodule

// File: tb/tb_mac_job_sequencer.sv
// tb_mac_job_sequencer
// Directed and random stimulus for mac_job_sequencer. A job-queue reference
// model predicts every output on every cycle.
module tb_mac_job_sequencer;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [9:0]  len;
        logic [5:0]  shift;
        logic        mul;
        logic [15:0] nb;
        logic [3:0]  id;
    } job_t;

    // Model job phases, named after the sequencing steps of a job
    localparam int PH_IDLE  = 0;
    localparam int PH_CLEAR = 1;
    localparam int PH_START = 2;
    localparam int PH_RUN   = 3;
    localparam int PH_WAIT  = 4;
    localparam int PH_DONE  = 5;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        soft_clear_i = 1'b0;
    logic        job_valid_i = 1'b0;
    logic        job_ready_o;
    logic [9:0]  job_len_i = '0;
    logic [5:0]  job_shift_i = '0;
    logic        job_simple_mul_i = 1'b0;
    logic [15:0] job_nb_out_i = '0;
    logic [3:0]  job_id_i = '0;
    logic        eng_clear_o;
    logic        eng_enable_o;
    logic        eng_start_o;
    logic [9:0]  eng_len_o;
    logic [5:0]  eng_shift_o;
    logic        eng_simple_mul_o;
    logic        d_valid_i = 1'b0;
    logic        d_ready_i = 1'b0;
    logic        strm_start_o;
    logic        strm_done_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [3:0]  done_id_o;
    logic [15:0] out_cnt_o;

    mac_job_sequencer #(
        .CNT_W(10), .NOUT_W(16), .ID_W(4), .JOB_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .soft_clear_i(soft_clear_i),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_len_i(job_len_i), .job_shift_i(job_shift_i),
        .job_simple_mul_i(job_simple_mul_i), .job_nb_out_i(job_nb_out_i),
        .job_id_i(job_id_i),
        .eng_clear_o(eng_clear_o), .eng_enable_o(eng_enable_o),
        .eng_start_o(eng_start_o), .eng_len_o(eng_len_o),
        .eng_shift_o(eng_shift_o), .eng_simple_mul_o(eng_simple_mul_o),
        .d_valid_i(d_valid_i), .d_ready_i(d_ready_i),
        .strm_start_o(strm_start_o), .strm_done_i(strm_done_i),
        .busy_o(busy_o), .done_o(done_o), .done_id_o(done_id_o),
        .out_cnt_o(out_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Bookkeeping
    int n_chk = 0;
    int n_err = 0;
    int cyc_no = 0;

    // Reference model state
    job_t mq[$];
    job_t act_m;
    int   ph_m;
    int   cnt_m;
    bit   sticky_m;

    // Observation logs
    logic [3:0] done_log[$];
    int  done_cyc;
    int  clr_cyc;
    int  n_starts;
    int  outcnt_at_done;
    bit  saw_nr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        act_m    = '0;
        ph_m     = PH_IDLE;
        cnt_m    = 0;
        sticky_m = 1'b0;
    endtask

    // Compare every DUT output with the model prediction for this cycle
    task automatic compare_all();
        logic [6:0] exp_ctl;
        logic [6:0] got_ctl;
        bit sc;
        sc = soft_clear_i;
        exp_ctl = {mq.size() < DEPTH,
                   (ph_m != PH_IDLE) || (mq.size() > 0),
                   sc || (ph_m == PH_CLEAR),
                   !sc && (ph_m == PH_START || ph_m == PH_RUN || ph_m == PH_WAIT),
                   !sc && (ph_m == PH_START),
                   !sc && (ph_m == PH_START),
                   !sc && (ph_m == PH_DONE)};
        got_ctl = {job_ready_o, busy_o, eng_clear_o, eng_enable_o,
                   eng_start_o, strm_start_o, done_o};
        check_eq("ctl{rdy,busy,clr,en,st,sst,done}", 64'(got_ctl), 64'(exp_ctl));
        check_eq("done_id", 64'(done_id_o),
                 (!sc && ph_m == PH_DONE) ? 64'(act_m.id) : 64'd0);
        check_eq("out_cnt", 64'(out_cnt_o), 64'(cnt_m));
        check_eq("eng_cfg", 64'({eng_len_o, eng_shift_o, eng_simple_mul_o}),
                 64'({act_m.len, act_m.shift, act_m.mul}));
    endtask

    // Advance the model across one rising edge with the given inputs
    task automatic model_advance(input bit v, input job_t j, input bit hs,
                                 input bit sd, input bit sc);
        int  nxt;
        bit  room;
        if (sc) begin
            mq.delete();
            ph_m     = PH_IDLE;
            cnt_m    = 0;
            sticky_m = 1'b0;
            return;
        end
        room = (mq.size() < DEPTH);
        nxt  = ph_m;
        case (ph_m)
            PH_IDLE: if (mq.size() > 0) begin
                act_m = mq.pop_front();
                nxt   = PH_CLEAR;
            end
            PH_CLEAR: begin
                cnt_m    = 0;
                sticky_m = 1'b0;
                nxt      = (act_m.nb == 0) ? PH_DONE : PH_START;
            end
            PH_START: begin
                if (sd) sticky_m = 1'b1;
                nxt = PH_RUN;
            end
            PH_RUN: begin
                if (sd) sticky_m = 1'b1;
                if (hs) begin
                    if (cnt_m == int'(act_m.nb) - 1) nxt = PH_WAIT;
                    if (cnt_m < int'(act_m.nb)) cnt_m++;
                end
            end
            PH_WAIT: begin
                if (sd || sticky_m) nxt = PH_DONE;
                if (sd) sticky_m = 1'b1;
            end
            default: nxt = PH_IDLE;
        endcase
        ph_m = nxt;
        if (v && room) mq.push_back(j);
    endtask

    // One clock cycle: drive inputs, check outputs, log events, advance model
    task automatic step(input bit v, input job_t j, input bit dv, input bit dr,
                        input bit sd, input bit sc);
        @(negedge clk_i);
        job_valid_i      = v;
        job_len_i        = j.len;
        job_shift_i      = j.shift;
        job_simple_mul_i = j.mul;
        job_nb_out_i     = j.nb;
        job_id_i         = j.id;
        d_valid_i        = dv;
        d_ready_i        = dr;
        strm_done_i      = sd;
        soft_clear_i     = sc;
        #1;
        compare_all();
        if (done_o) begin
            done_log.push_back(done_id_o);
            done_cyc       = cyc_no;
            outcnt_at_done = int'(out_cnt_o);
        end
        if (eng_clear_o && clr_cyc < 0) clr_cyc = cyc_no;
        if (eng_start_o) n_starts++;
        if (!job_ready_o) saw_nr = 1'b1;
        model_advance(v, j, dv && dr, sd, sc);
        cyc_no++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle, released at a falling edge
    task automatic do_reset();
        @(negedge clk_i);
        job_valid_i  = 1'b0;
        d_valid_i    = 1'b0;
        d_ready_i    = 1'b0;
        strm_done_i  = 1'b0;
        soft_clear_i = 1'b0;
        rst_ni       = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        compare_all();
    endtask

    task automatic start_scenario();
        done_log.delete();
        done_cyc = -1;
        clr_cyc  = -1;
        saw_nr   = 1'b0;
        outcnt_at_done = -1;
    endtask

    function automatic job_t mk(input int len, input int sh, input int mul,
                                input int nb, input int id);
        job_t j;
        j.len   = 10'(len);
        j.shift = 6'(sh);
        j.mul   = 1'(mul);
        j.nb    = 16'(nb);
        j.id    = 4'(id);
        return j;
    endfunction

    function automatic logic [3:0] log_at(input int i);
        return (i < done_log.size()) ? done_log[i] : 4'hx;
    endfunction

    initial begin
        int p;
        int s0;
        job_t jr;
        model_reset();
        do_reset();
        check_eq("reset_ready", 64'(job_ready_o), 64'd1);
        check_eq("reset_busy", 64'(busy_o), 64'd0);

        // Single job: one handshake, streamer done two cycles later
        start_scenario();
        p = cyc_no;
        step(1'b1, mk(8, 0, 0, 1, 3), 0, 0, 0, 0);
        idle(3);                                   // idle, clear, start
        step(1'b0, '0, 1, 1, 0, 0);                // handshake in RUN
        idle(1);
        step(1'b0, '0, 0, 0, 1, 0);                // streamer done
        idle(2);
        check_eq("s1_clear_lat", 64'(clr_cyc - p), 64'd2);
        check_eq("s1_done_lat", 64'(done_cyc - p), 64'd7);
        check_eq("s1_done_id", 64'(log_at(0)), 64'd3);
        check_eq("s1_busy_after", 64'(busy_o), 64'd0);

        // Back-to-back jobs with the FIFO filling up
        start_scenario();
        step(1'b1, mk(4, 1, 0, 2, 1), 0, 0, 0, 0);
        step(1'b1, mk(5, 2, 0, 2, 2), 0, 0, 0, 0);
        step(1'b1, mk(6, 3, 1, 2, 3), 0, 0, 0, 0);
        for (int i = 0; i < 100 && done_log.size() < 3; i++) step(1'b0, '0, 1, 1, 1, 0);
        check_eq("s2_ready_low_seen", 64'(saw_nr), 64'd1);
        check_eq("s2_n_done", 64'(done_log.size()), 64'd3);
        check_eq("s2_order0", 64'(log_at(0)), 64'd1);
        check_eq("s2_order1", 64'(log_at(1)), 64'd2);
        check_eq("s2_order2", 64'(log_at(2)), 64'd3);
        idle(2);

        // Mode select, five outputs, ready toggling
        start_scenario();
        step(1'b1, mk(20, 5, 1, 5, 5), 0, 0, 0, 0);
        for (int i = 0; i < 80 && done_log.size() == 0; i++)
            step(1'b0, '0, 1, (i % 2 == 0), (i % 7 == 6), 0);
        check_eq("s3_done_id", 64'(log_at(0)), 64'd5);
        check_eq("s3_cnt_at_done", 64'(outcnt_at_done), 64'd5);
        idle(2);

        // Early streamer done during START
        start_scenario();
        p = cyc_no;
        step(1'b1, mk(3, 0, 0, 2, 4), 0, 0, 0, 0);
        idle(2);
        step(1'b0, '0, 0, 0, 1, 0);                // START with streamer done
        step(1'b0, '0, 1, 1, 0, 0);
        step(1'b0, '0, 1, 1, 0, 0);
        idle(3);
        check_eq("s4_done_lat", 64'(done_cyc - p), 64'd7);
        check_eq("s4_done_id", 64'(log_at(0)), 64'd4);

        // Zero-output job never starts the engine
        start_scenario();
        p  = cyc_no;
        s0 = n_starts;
        step(1'b1, mk(9, 0, 0, 0, 7), 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1, 1, 1, 0);
        check_eq("s5_no_start", 64'(n_starts - s0), 64'd0);
        check_eq("s5_done_lat", 64'(done_cyc - p), 64'd3);
        check_eq("s5_done_id", 64'(log_at(0)), 64'd7);

        // Soft clear in RUN with a job queued, then a fresh job
        start_scenario();
        step(1'b1, mk(11, 1, 0, 4, 10), 0, 0, 0, 0);
        step(1'b1, mk(12, 2, 0, 4, 11), 0, 0, 0, 0);
        idle(2);
        step(1'b0, '0, 1, 1, 0, 1);
        check_eq("s6_clear_in_abort", 64'(eng_clear_o), 64'd1);
        check_eq("s6_enable_in_abort", 64'(eng_enable_o), 64'd0);
        idle(1);
        check_eq("s6_busy_after", 64'(busy_o), 64'd0);
        idle(4);
        check_eq("s6_no_done", 64'(done_log.size()), 64'd0);
        step(1'b1, mk(2, 0, 0, 1, 12), 0, 0, 0, 0);
        for (int i = 0; i < 30 && done_log.size() == 0; i++) step(1'b0, '0, 1, 1, 1, 0);
        check_eq("s6_next_job", 64'(log_at(0)), 64'd12);

        // Asynchronous reset in RUN, then a fresh job
        start_scenario();
        step(1'b1, mk(11, 1, 0, 4, 10), 0, 0, 0, 0);
        step(1'b1, mk(12, 2, 0, 4, 11), 0, 0, 0, 0);
        idle(2);
        step(1'b0, '0, 1, 1, 0, 0);
        do_reset();
        check_eq("s7_busy_after", 64'(busy_o), 64'd0);
        idle(4);
        check_eq("s7_no_done", 64'(done_log.size()), 64'd0);
        step(1'b1, mk(2, 0, 0, 1, 13), 0, 0, 0, 0);
        for (int i = 0; i < 30 && done_log.size() == 0; i++) step(1'b0, '0, 1, 1, 1, 0);
        check_eq("s7_next_job", 64'(log_at(0)), 64'd13);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(499) == 0) begin
                do_reset();
            end else begin
                jr = mk($urandom_range(1023), $urandom_range(63), $urandom_range(1),
                        $urandom_range(4), $urandom_range(15));
                step($urandom_range(2) == 0, jr, $urandom_range(1) == 1,
                     $urandom_range(1) == 1, $urandom_range(7) == 0,
                     $urandom_range(63) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
